// File: rtl/fifo2ddr_pkg.sv
// Shared definitions for the FIFO-to-DDR write controller: FSM encoding,
// AXI4 constants and the burst byte-count helper.
package fifo2ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Bytes moved by one burst of len beats of dw bits each.
  function automatic int unsigned burst_bytes(input int unsigned len, input int unsigned dw);
    return len * (dw / 8);
  endfunction

endpackage

// File: rtl/fifo2ddr_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between the controller and the DDR slave.
// Every channel follows valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised, the payload and
// valid stay unchanged until that transfer. Ready may change freely.
interface fifo2ddr_wr_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/fifo2ddr_addr_gen.sv
// Burst start-address register walking a circular region: advances by one
// burst's byte count per retired burst and wraps back to the region base.
module fifo2ddr_addr_gen
  import fifo2ddr_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    BURST_LEN    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(32'h1000)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  localparam int AW1 = ADDR_WIDTH + 1;
  // One extra bit so the sum and the limit cannot overflow at the top of the map.
  localparam logic [ADDR_WIDTH:0] STEP  = AW1'(burst_bytes(BURST_LEN, DATA_WIDTH));
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, REGION_BYTES};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   next_sum;

  // Next address: step forward, wrap to base once the region end is reached.
  always_comb begin
    next_sum = {1'b0, addr_q} + STEP;
    addr_d   = addr_q;
    if (i_advance) begin
      addr_d = (next_sum >= LIMIT) ? BASE_ADDR : next_sum[ADDR_WIDTH-1:0];
    end
  end

  // Address register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) addr_q <= BASE_ADDR;
    else         addr_q <= addr_d;
  end

  assign o_addr = addr_q;

endmodule

// File: rtl/fifo2ddr_wr_ctrl.sv
// Drains FIFO words into fixed-length AXI4 INCR write bursts over a circular
// DDR region. FSM IDLE -> AW -> DATA -> RESP; W data passes through a
// one-entry hold register fed by single-cycle FIFO read pulses.
// Optional build macro FIFO2DDR_ERRCNT_EN adds o_err_cnt, a saturating count
// of B responses other than OKAY.
module fifo2ddr_wr_ctrl
  import fifo2ddr_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    BURST_LEN    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(32'h1000)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_enable,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  i_fifo_data,
  fifo2ddr_wr_ctrl_if.master     axi,
  output logic                   o_busy,
  output state_e                 o_state
`ifdef FIFO2DDR_ERRCNT_EN
  ,
  output logic [7:0]             o_err_cnt
`endif
);

  localparam int                CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  BL_C  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  BL_M1 = CNT_W'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      ld_cnt_q, ld_cnt_d;
  logic                  rd_en;
  logic                  w_hs;
  logic                  b_hs;
  logic [ADDR_WIDTH-1:0] addr;

  assign w_hs = wvalid_q && axi.wready;
  assign b_hs = (state_q == ST_RESP) && axi.bvalid;

  fifo2ddr_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .BURST_LEN   (BURST_LEN),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BYTES(REGION_BYTES)
  ) u_addr_gen (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_advance(b_hs),
    .o_addr   (addr)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; enable only gates the start of a new burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_enable && !i_fifo_empty) state_d = ST_AW;
      ST_AW:   if (axi.awready)               state_d = ST_DATA;
      ST_DATA: if (w_hs && wlast_q)           state_d = ST_RESP;
      ST_RESP: if (axi.bvalid)                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. A read may issue while the held beat is being accepted, so
  // the refill lands right after and W reaches one beat every two cycles.
  always_comb begin
    rd_en = (state_q == ST_DATA) && !rd_inflight_q && (!wvalid_q || axi.wready) &&
            !i_fifo_empty && (rd_cnt_q < BL_C);
    axi.awvalid = (state_q == ST_AW);
    axi.bready  = (state_q == ST_RESP);
    o_busy      = (state_q != ST_IDLE);
  end

  // Hold register and burst counters: load one cycle after each read pulse,
  // clear valid on acceptance, restart the counts when a burst is announced.
  always_comb begin
    wvalid_d      = wvalid_q;
    wlast_d       = wlast_q;
    wdata_d       = wdata_q;
    rd_inflight_d = rd_en;
    rd_cnt_d      = rd_cnt_q;
    ld_cnt_d      = ld_cnt_q;
    if (state_q == ST_AW) begin
      rd_cnt_d = '0;
      ld_cnt_d = '0;
    end
    if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
    if (w_hs) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
    if (rd_inflight_q) begin
      wvalid_d = 1'b1;
      wdata_d  = i_fifo_data;
      wlast_d  = (ld_cnt_q == BL_M1);
      ld_cnt_d = ld_cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      wdata_q       <= '0;
      rd_inflight_q <= 1'b0;
      rd_cnt_q      <= '0;
      ld_cnt_q      <= '0;
    end else begin
      wvalid_q      <= wvalid_d;
      wlast_q       <= wlast_d;
      wdata_q       <= wdata_d;
      rd_inflight_q <= rd_inflight_d;
      rd_cnt_q      <= rd_cnt_d;
      ld_cnt_q      <= ld_cnt_d;
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign o_state      = state_q;
  assign axi.awaddr   = addr;
  assign axi.awlen    = 8'(BURST_LEN - 1);
  assign axi.awsize   = 3'($clog2(DATA_WIDTH / 8));
  assign axi.awburst  = BURST_INCR;
  assign axi.wdata    = wdata_q;
  assign axi.wstrb    = '1;
  assign axi.wlast    = wlast_q;
  assign axi.wvalid   = wvalid_q;

`ifdef FIFO2DDR_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Error counter: one step per non-OKAY B handshake, sticks at 8'hFF.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (b_hs && (axi.bresp != RESP_OKAY) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) err_cnt_q <= 8'd0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`else
  // Response code carries no meaning without the error counter.
  logic unused_bresp;
  assign unused_bresp = ^axi.bresp;
`endif

endmodule

// File: tb/tb_fifo2ddr_wr_ctrl.sv
// Bench for fifo2ddr_wr_ctrl: FIFO and AXI slave models, a beat scoreboard
// and burst-address arithmetic. Define FIFO2DDR_ERRCNT_EN to cover o_err_cnt.
module tb_fifo2ddr_wr_ctrl;
  import fifo2ddr_pkg::*;

  localparam int          DW     = 16;
  localparam int          AW     = 32;
  localparam int          BL     = 4;
  localparam int          BB     = BL * DW / 8;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          REGION = 16;

  // clock / reset
  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_enable;
  logic          i_fifo_empty;
  logic          o_fifo_rd_en;
  logic [DW-1:0] i_fifo_data;
  logic          o_busy;
  state_e        o_state;
`ifdef FIFO2DDR_ERRCNT_EN
  logic [7:0]    o_err_cnt;
`endif

  fifo2ddr_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  fifo2ddr_wr_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BURST_LEN   (BL),
    .BASE_ADDR   (BASE),
    .REGION_BYTES(32'(REGION))
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_enable    (i_enable),
    .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd_en(o_fifo_rd_en),
    .i_fifo_data (i_fifo_data),
    .axi         (axi),
    .o_busy      (o_busy),
    .o_state     (o_state)
`ifdef FIFO2DDR_ERRCNT_EN
    ,
    .o_err_cnt   (o_err_cnt)
`endif
  );

  // scoreboard and model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   bp_en = 1'b0;
  bit   rd_seen = 1'b0;
  bit   b_hs = 1'b0;
  bit   b_pending = 1'b0;
  int   b_delay = 0;
  logic [1:0] resp_val = RESP_OKAY;
  int   bursts_done = 0;
  int   beats_in_burst = 0;
  int   aw_count = 0;
  int   rd_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic sync();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_bursts(input int n, input int budget);
    int i = 0;
    while (bursts_done < n && i < budget) begin
      @(posedge i_clk);
      i++;
    end
    check("wait_bursts", 64'(bursts_done >= n), 64'd1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int i = 0;
    while (beats_in_burst < n && i < budget) begin
      @(posedge i_clk);
      i++;
    end
    check("wait_beats", 64'(beats_in_burst >= n), 64'd1);
  endtask

  // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
  initial begin : monitor
    bit            aw_stall;
    bit            w_stall;
    logic [AW-1:0] aw_addr_h;
    logic [DW-1:0] w_data_h;
    logic          w_last_h;
    logic [AW-1:0] ea;
    aw_stall = 1'b0;
    w_stall  = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        aw_stall = 1'b0;
        w_stall  = 1'b0;
        rd_seen  = 1'b0;
        continue;
      end
      if (aw_stall) begin
        check("aw_hold_valid", 64'(axi.awvalid), 64'd1);
        check("aw_hold_addr", 64'(axi.awaddr), 64'(aw_addr_h));
      end
      if (w_stall) begin
        check("w_hold_valid", 64'(axi.wvalid), 64'd1);
        check("w_hold_data", 64'(axi.wdata), 64'(w_data_h));
        check("w_hold_last", 64'(axi.wlast), 64'(w_last_h));
      end
      if (o_fifo_rd_en) check("rd_en_nonempty", 64'(i_fifo_empty), 64'd0);
      rd_seen = o_fifo_rd_en;
      if (axi.awvalid && axi.awready) begin
        ea = BASE + AW'((bursts_done * BB) % REGION);
        check("aw_addr", 64'(axi.awaddr), 64'(ea));
        check("aw_len", 64'(axi.awlen), 64'(BL - 1));
        check("aw_size", 64'(axi.awsize), 64'd1);
        check("aw_burst", 64'(axi.awburst), 64'(BURST_INCR));
        aw_count++;
      end
      if (axi.wvalid && axi.wready) begin
        if (exp_q.size() == 0) begin
          check("w_unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          check("w_data", 64'(axi.wdata), 64'(exp_q.pop_front()));
        end
        check("w_last", 64'(axi.wlast), 64'(beats_in_burst == BL - 1));
        check("w_strb", 64'(axi.wstrb), 64'h3);
        beats_in_burst++;
        if (axi.wlast) begin
          b_pending = 1'b1;
          b_delay   = bp_en ? int'($urandom_range(0, 3)) : 0;
        end
      end
      if (axi.bvalid && axi.bready) begin
        check("b_beats", 64'(beats_in_burst), 64'(BL));
        beats_in_burst = 0;
        bursts_done++;
        b_hs = 1'b1;
      end
      aw_stall  = axi.awvalid && !axi.awready;
      aw_addr_h = axi.awaddr;
      w_stall   = axi.wvalid && !axi.wready;
      w_data_h  = axi.wdata;
      w_last_h  = axi.wlast;
    end
  end

  // FIFO and AXI slave models: all inputs change 1 time unit after the rising edge.
  initial begin : env
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    axi.awready  = 1'b0;
    axi.wready   = 1'b0;
    axi.bvalid   = 1'b0;
    axi.bresp    = RESP_OKAY;
    forever begin
      @(posedge i_clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) begin
        i_fifo_data = fifo_q.pop_front();
        rd_count++;
      end
      rd_seen      = 1'b0;
      i_fifo_empty = (fifo_q.size() == 0);
      axi.awready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready   = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_hs) begin
        axi.bvalid = 1'b0;
        b_hs       = 1'b0;
      end
      if (b_pending && i_rstn) begin
        if (b_delay == 0) begin
          axi.bvalid = 1'b1;
          axi.bresp  = resp_val;
          b_pending  = 1'b0;
        end else begin
          b_delay--;
        end
      end
    end
  end

  // directed sequence
  initial begin : main
    int bad;
    int rd0;
    int b0;
    int aw0;
    i_enable = 1'b0;

    // reset values
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("rst_wlast", 64'(axi.wlast), 64'd0);
    check("rst_rd_en", 64'(o_fifo_rd_en), 64'd0);
    check("rst_bready", 64'(axi.bready), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_wdata", 64'(axi.wdata), 64'd0);
`ifdef FIFO2DDR_ERRCNT_EN
    check("rst_err_cnt", 64'(o_err_cnt), 64'd0);
`endif
    sync();
    i_rstn = 1'b1;

    // enabled with an empty FIFO: nothing may happen
    i_enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge i_clk);
      if (axi.awvalid || o_fifo_rd_en || o_busy) bad++;
    end
    check("idle_when_empty", 64'(bad), 64'd0);

    // one burst of 1..4 with no backpressure
    sync();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    wait_bursts(1, 200);
    check("b1_aw_count", 64'(aw_count), 64'd1);
    check("b1_rd_count", 64'(rd_count), 64'd4);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("b1_idle_busy", 64'(o_busy), 64'd0);

    // random backpressure and a FIFO that trickles in; three bursts wrap the region
    sync();
    bp_en = 1'b1;
    rd0 = rd_count;
    b0  = bursts_done;
    for (int i = 0; i < 12; i++) begin
      push_word(DW'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge i_clk);
      #2;
    end
    wait_bursts(b0 + 3, 1000);
    check("bp_reads_per_burst", 64'(rd_count - rd0), 64'(BL * (bursts_done - b0)));

    // back-to-back bursts without backpressure
    sync();
    bp_en = 1'b0;
    b0 = bursts_done;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    wait_bursts(b0 + 2, 400);

    // enable dropped during beat 2: burst completes, no new burst
    sync();
    b0 = bursts_done;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    wait_beats(1, 200);
    sync();
    i_enable = 1'b0;
    wait_bursts(b0 + 1, 200);
    aw0 = aw_count;
    repeat (30) @(posedge i_clk);
    @(negedge i_clk);
    check("en_off_busy", 64'(o_busy), 64'd0);
    check("en_off_no_aw", 64'(aw_count), 64'(aw0));
    check("en_off_fifo_left", 64'(fifo_q.size()), 64'd4);
    sync();
    i_enable = 1'b1;
    wait_bursts(b0 + 2, 200);

`ifdef FIFO2DDR_ERRCNT_EN
    // two SLVERR responses are counted and the bursts still retire
    sync();
    resp_val = 2'b10;
    b0 = bursts_done;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    wait_bursts(b0 + 2, 400);
    resp_val = RESP_OKAY;
    @(negedge i_clk);
    check("err_cnt_two", 64'(o_err_cnt), 64'd2);
`endif

    // reset pulse in the middle of a burst
    sync();
    bp_en = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    wait_beats(2, 300);
    sync();
    check("busy_before_rst", 64'(o_busy), 64'd1);
    i_rstn = 1'b0;
    #1;
    check("mid_rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("mid_rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("mid_rst_wlast", 64'(axi.wlast), 64'd0);
    check("mid_rst_rd_en", 64'(o_fifo_rd_en), 64'd0);
    check("mid_rst_bready", 64'(axi.bready), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_wdata", 64'(axi.wdata), 64'd0);
`ifdef FIFO2DDR_ERRCNT_EN
    check("mid_rst_err_cnt", 64'(o_err_cnt), 64'd0);
`endif
    fifo_q.delete();
    exp_q.delete();
    beats_in_burst = 0;
    bursts_done    = 0;
    b_pending      = 1'b0;
    b_hs           = 1'b0;
    axi.bvalid     = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    i_rstn = 1'b1;

    // after reset the address restarts at the region base
    sync();
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    wait_bursts(1, 400);
    check("post_rst_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    repeat (5) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
